// File: rtl/state_log_scheduler.sv
// Multi-channel state-transition recorder: per-channel change detect, round-robin
// arbitration into a circular log. Optional STATE_LOG_OVERWRITE_EN: full log drops oldest.
module state_log_scheduler #(
  parameter  int CH    = 4,
  parameter  int BITS  = 8,
  parameter  int DEPTH = 16,
  localparam int CIDW  = (CH > 1) ? $clog2(CH) : 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int EW    = CIDW + 2 * BITS
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iClear,
  input  logic [CH*BITS-1:0]   iDbgSt,
  input  logic                 iRdEn,
  output logic [EW-1:0]        oRdData,
  output logic                 oRdValid,
  output logic [AW:0]          oCount,
  output logic [CH-1:0]        oPending,
  output logic                 oOverflow,
  output logic                 oCoalesce
);

  logic [BITS-1:0] state_in    [CH];
  logic [BITS-1:0] cur_reg     [CH];
  logic [BITS-1:0] ev_prev_reg [CH];
  logic [BITS-1:0] ev_curr_reg [CH];
  logic [CH-1:0]   changed;
  logic [CH-1:0]   granted;
  logic [CH-1:0]   coal;
  logic [CH-1:0]   pending_reg;

  logic [CIDW-1:0] rr_reg;
  logic [CIDW-1:0] gnt_idx;
  logic            gnt_valid;

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic [EW-1:0]   rd_data_reg;
  logic            rd_valid_reg;
  logic            overflow_reg;
  logic            coalesce_reg;

  logic            do_read;
  logic            full;
  logic            lost;
  logic            wr_en;
  logic            adv_rd;
  logic            cnt_inc;
  logic [EW-1:0]   wr_data;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      assign state_in[gi] = iDbgSt[gi*BITS +: BITS];
      assign changed[gi]  = (state_in[gi] != cur_reg[gi]);
      assign granted[gi]  = gnt_valid && (gnt_idx == CIDW'(gi));
      // A change on a still-waiting channel folds into its existing event.
      assign coal[gi]     = changed[gi] && pending_reg[gi] && !granted[gi];
    end
  endgenerate

  always_comb begin
    logic [CIDW-1:0] idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int i = 0; i < CH; i++) begin
      idx = CIDW'((int'(rr_reg) + i) % CH);
      if (!gnt_valid && pending_reg[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  assign do_read = iRdEn && (count_reg != '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign lost    = gnt_valid && full && !do_read;
  assign cnt_inc = gnt_valid && !lost;
  assign wr_data = {gnt_idx, ev_prev_reg[gnt_idx], ev_curr_reg[gnt_idx]};

`ifdef STATE_LOG_OVERWRITE_EN
  assign wr_en  = gnt_valid;
  assign adv_rd = do_read || lost;
`else
  assign wr_en  = gnt_valid && !lost;
  assign adv_rd = do_read;
`endif

  always_ff @(posedge iClk) begin
    if (iRst_n && !iClear && wr_en)
      mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n || iClear) begin
      for (int k = 0; k < CH; k++) begin
        cur_reg[k]     <= state_in[k];
        ev_prev_reg[k] <= '0;
        ev_curr_reg[k] <= '0;
      end
      pending_reg  <= '0;
      rr_reg       <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      overflow_reg <= 1'b0;
      coalesce_reg <= 1'b0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (changed[k]) begin
          cur_reg[k]     <= state_in[k];
          ev_curr_reg[k] <= state_in[k];
          if (!pending_reg[k] || granted[k])
            ev_prev_reg[k] <= cur_reg[k];
        end
      end
      pending_reg <= (pending_reg & ~granted) | changed;
      if (|coal)
        coalesce_reg <= 1'b1;
      if (gnt_valid)
        rr_reg <= (gnt_idx == CIDW'(CH - 1)) ? '0 : gnt_idx + 1'b1;
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (adv_rd)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (lost)
        overflow_reg <= 1'b1;
      count_reg    <= count_reg + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, do_read};
      rd_valid_reg <= do_read;
      if (do_read)
        rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  assign oRdData   = rd_data_reg;
  assign oRdValid  = rd_valid_reg;
  assign oCount    = count_reg;
  assign oPending  = pending_reg;
  assign oOverflow = overflow_reg;
  assign oCoalesce = coalesce_reg;

endmodule

// File: tb/tb_state_log_scheduler.sv
// Directed bench for state_log_scheduler: vector table plus multi-cycle corner sequences.
module tb_state_log_scheduler;

  logic        iClk;
  logic        iRst_n;
  logic        iClear;
  logic [31:0] iDbgSt;
  logic        iRdEn;
  logic [17:0] oRdData;
  logic        oRdValid;
  logic [4:0]  oCount;
  logic [3:0]  oPending;
  logic        oOverflow;
  logic        oCoalesce;

  int total = 0;
  int bad   = 0;

  state_log_scheduler dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iClear    (iClear),
    .iDbgSt    (iDbgSt),
    .iRdEn     (iRdEn),
    .oRdData   (oRdData),
    .oRdValid  (oRdValid),
    .oCount    (oCount),
    .oPending  (oPending),
    .oOverflow (oOverflow),
    .oCoalesce (oCoalesce)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic [31:0] dbg;
    logic        rd;
    logic        clr;
    logic [4:0]  cnt;
    logic [3:0]  pend;
    logic        vld;
    logic [17:0] dat;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic [31:0] d, input logic rd, input logic clr);
    iDbgSt = d;
    iRdEn  = rd;
    iClear = clr;
    @(posedge iClk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{32'h0000_0011, 1'b0, 1'b0, 5'd0, 4'b0000, 1'b0, 18'h00000};
    tbl[1]  = '{32'h0000_0022, 1'b0, 1'b0, 5'd0, 4'b0001, 1'b0, 18'h00000};
    tbl[2]  = '{32'h0000_0022, 1'b0, 1'b0, 5'd1, 4'b0000, 1'b0, 18'h00000};
    tbl[3]  = '{32'h0000_0022, 1'b1, 1'b0, 5'd0, 4'b0000, 1'b1, 18'h01122};
    tbl[4]  = '{32'h0000_0022, 1'b1, 1'b0, 5'd0, 4'b0000, 1'b0, 18'h01122};
    tbl[5]  = '{32'h0000_0022, 1'b0, 1'b1, 5'd0, 4'b0000, 1'b0, 18'h00000};
    tbl[6]  = '{32'h4433_2211, 1'b0, 1'b0, 5'd0, 4'b1111, 1'b0, 18'h00000};
    tbl[7]  = '{32'h4433_2211, 1'b0, 1'b0, 5'd1, 4'b1110, 1'b0, 18'h00000};
    tbl[8]  = '{32'h4433_2211, 1'b0, 1'b0, 5'd2, 4'b1100, 1'b0, 18'h00000};
    tbl[9]  = '{32'h4433_2211, 1'b0, 1'b0, 5'd3, 4'b1000, 1'b0, 18'h00000};
    tbl[10] = '{32'h4433_2211, 1'b0, 1'b0, 5'd4, 4'b0000, 1'b0, 18'h00000};
    tbl[11] = '{32'h4433_2211, 1'b1, 1'b0, 5'd3, 4'b0000, 1'b1, 18'h02211};
    tbl[12] = '{32'h4433_2211, 1'b1, 1'b0, 5'd2, 4'b0000, 1'b1, 18'h10022};
    tbl[13] = '{32'h4433_2211, 1'b1, 1'b0, 5'd1, 4'b0000, 1'b1, 18'h20033};
    tbl[14] = '{32'h4433_2211, 1'b1, 1'b0, 5'd0, 4'b0000, 1'b1, 18'h30044};
    tbl[15] = '{32'h4433_2211, 1'b0, 1'b0, 5'd0, 4'b0000, 1'b0, 18'h30044};

    iRst_n = 1'b0;
    iClear = 1'b0;
    iRdEn  = 1'b0;
    iDbgSt = 32'h0000_0011;

    // Reset held three cycles with a live input: no event may appear.
    for (int i = 0; i < 3; i++) begin
      tick(32'h0000_0011, 1'b0, 1'b0);
      chk("rst_count", 32'(oCount), 32'd0);
      chk("rst_pending", 32'(oPending), 32'd0);
      chk("rst_valid", 32'(oRdValid), 32'd0);
      chk("rst_data", 32'(oRdData), 32'd0);
    end
    iRst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].dbg, tbl[i].rd, tbl[i].clr);
      $display("vec %0d: dbg=%h rd=%0d clr=%0d -> cnt=%0d pend=%b vld=%0d dat=%h",
               i, tbl[i].dbg, tbl[i].rd, tbl[i].clr, oCount, oPending, oRdValid, oRdData);
      chk($sformatf("vec%0d_count", i), 32'(oCount), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_pending", i), 32'(oPending), 32'(tbl[i].pend));
      chk($sformatf("vec%0d_valid", i), 32'(oRdValid), 32'(tbl[i].vld));
      chk($sformatf("vec%0d_data", i), 32'(oRdData), 32'(tbl[i].dat));
    end

    // Coalescing: ch2 changes twice while ch0/ch1 hold the grant.
    tick(32'h0001_0000, 1'b0, 1'b1);
    tick(32'h0002_0A0B, 1'b0, 1'b0);
    chk("coal_pend0", 32'(oPending), 32'b0111);
    tick(32'h0003_0A0B, 1'b0, 1'b0);
    chk("coal_pend1", 32'(oPending), 32'b0110);
    chk("coal_flag", 32'(oCoalesce), 32'd1);
    tick(32'h0003_0A0B, 1'b0, 1'b0);
    tick(32'h0003_0A0B, 1'b0, 1'b0);
    chk("coal_count", 32'(oCount), 32'd3);
    tick(32'h0003_0A0B, 1'b1, 1'b0);
    chk("coal_pop0", 32'(oRdData), 32'h0000B);
    tick(32'h0003_0A0B, 1'b1, 1'b0);
    chk("coal_pop1", 32'(oRdData), 32'h1000A);
    tick(32'h0003_0A0B, 1'b1, 1'b0);
    chk("coal_pop2", 32'(oRdData), 32'h20103);
    $display("coalesce seq: cnt=%0d coal=%0d", oCount, oCoalesce);

    // Fill past capacity: 17 events on ch0, one per cycle.
    tick(32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++)
      tick(32'(i + 1), 1'b0, 1'b0);
    tick(32'd17, 1'b0, 1'b0);
    tick(32'd17, 1'b0, 1'b0);
    chk("ovf_count", 32'(oCount), 32'd16);
    chk("ovf_flag", 32'(oOverflow), 32'd1);
    tick(32'd17, 1'b1, 1'b0);
    chk("ovf_valid", 32'(oRdValid), 32'd1);
`ifdef STATE_LOG_OVERWRITE_EN
    chk("ovf_first_pop", 32'(oRdData), 32'h00102);
`else
    chk("ovf_first_pop", 32'(oRdData), 32'h00001);
`endif
    $display("overflow seq: cnt=%0d ovf=%0d dat=%h", oCount, oOverflow, oRdData);

    // Full buffer with a pop on the same edge as a new write.
    tick(32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++)
      tick(32'(i + 1), 1'b0, 1'b0);
    tick(32'd16, 1'b0, 1'b0);
    chk("full_count", 32'(oCount), 32'd16);
    tick(32'd17, 1'b0, 1'b0);
    chk("full_pending", 32'(oPending), 32'b0001);
    tick(32'd17, 1'b1, 1'b0);
    chk("fullrw_count", 32'(oCount), 32'd16);
    chk("fullrw_ovf", 32'(oOverflow), 32'd0);
    chk("fullrw_valid", 32'(oRdValid), 32'd1);
    chk("fullrw_data", 32'(oRdData), 32'h00001);
    $display("full rw seq: cnt=%0d ovf=%0d dat=%h", oCount, oOverflow, oRdData);

    // Clear mid-drain with five entries stored and an input change on the same edge.
    tick(32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      tick(32'(i + 1), 1'b0, 1'b0);
    tick(32'd5, 1'b0, 1'b0);
    tick(32'd5, 1'b1, 1'b0);
    chk("clr_pre_count", 32'(oCount), 32'd4);
    tick(32'd5, 1'b0, 1'b0);
    chk("clr_pre_count2", 32'(oCount), 32'd4);
    tick(32'd5, 1'b0, 1'b0);
    tick(32'h0000_0099, 1'b1, 1'b0);
    chk("clr_pend_new", 32'(oPending), 32'b0001);
    tick(32'h0000_0099, 1'b0, 1'b0);
    chk("clr_count5", 32'(oCount), 32'd4);
    tick(32'h0000_0077, 1'b1, 1'b1);
    chk("clr_count", 32'(oCount), 32'd0);
    chk("clr_valid", 32'(oRdValid), 32'd0);
    chk("clr_pending", 32'(oPending), 32'd0);
    chk("clr_ovf", 32'(oOverflow), 32'd0);
    chk("clr_coal", 32'(oCoalesce), 32'd0);
    chk("clr_data", 32'(oRdData), 32'd0);
    tick(32'h0000_0077, 1'b0, 1'b0);
    chk("clr_baseline_pend", 32'(oPending), 32'd0);
    tick(32'h0000_0077, 1'b1, 1'b0);
    chk("clr_baseline_count", 32'(oCount), 32'd0);
    chk("clr_empty_valid", 32'(oRdValid), 32'd0);
    $display("clear seq: cnt=%0d pend=%b vld=%0d", oCount, oPending, oRdValid);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
